// File: rtl/parity_unload_pkg.sv
// Shared constants, state encoding and buffered-word payload for the parity unload path.
package parity_unload_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned NUM_WORDS = 6;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned CNT_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } word_t;

endpackage

// File: rtl/parity_skid_fifo.sv
// Two-entry output skid FIFO; entry 0 is always the head so out_data comes straight from a flop.
module parity_skid_fifo
    import parity_unload_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [WORD_W:0] wr_word,
    output logic [WORD_W:0] head,
    output logic            full,
    output logic            empty,
    output logic [1:0]      occ
);

    word_t      e0_q, e0_d;
    word_t      e1_q, e1_d;
    logic [1:0] occ_q, occ_d;
    logic       pop_ok;

    assign pop_ok = pop && (occ_q != 2'd0);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    e0_d  = wr_word;
                    occ_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop_ok) begin
                    e0_d = wr_word;
                end else if (push) begin
                    e1_d  = wr_word;
                    occ_d = 2'd2;
                end else if (pop_ok) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                if (pop_ok) begin
                    e0_d = e1_q;
                    if (push) begin
                        e1_d = wr_word;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head  = e0_q;
    assign full  = (occ_q == 2'd2);
    assign empty = (occ_q == 2'd0);
    assign occ   = occ_q;

endmodule

// File: rtl/parity_unload.sv
// Counts the parity load burst, then reads the bank back and streams the words over valid/ready.
module parity_unload
    import parity_unload_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst,
    input  logic              p_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] par_data,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              ovr_err
);

    state_e            state_q, state_d;
    logic              p_en_q;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  push_idx_q, push_idx_d;
    logic              inflight_q;
    logic              last_xfer_q, last_xfer_d;
    logic              len_err_q, len_err_d;
    logic              ovr_err_q, ovr_err_d;

    word_t             push_word;
    word_t             head;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_occ;
    logic              p_fall, p_rise, pop, credit_ok, rd_en_c, done_c;

    assign p_fall = p_en_q && !p_en;
    assign p_rise = p_en && !p_en_q;
    assign pop    = !fifo_empty && out_ready;
    assign done_c = pop && head.last;

    // A new read is allowed only if its word will still have a FIFO slot when it lands.
    assign credit_ok = (3'(fifo_occ) + 3'(inflight_q)) < (3'd2 + 3'(pop));
    assign rd_en_c   = (state_q == READ) && credit_ok && !(fifo_full && !pop);

    assign push_word.last = (push_idx_q == CNT_W'(NUM_WORDS - 1));
    assign push_word.data = par_data;

    parity_skid_fifo u_fifo (
        .clk_in  (clk_in),
        .rst     (rst),
        .push    (inflight_q),
        .pop     (pop),
        .wr_word (push_word),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .occ     (fifo_occ)
    );

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        rd_addr_d   = rd_addr_q;
        push_idx_d  = push_idx_q;
        last_xfer_d = last_xfer_q;
        len_err_d   = 1'b0;
        ovr_err_d   = 1'b0;

        if (inflight_q) begin
            push_idx_d = push_idx_q + CNT_W'(1);
        end
        if (rd_en_c) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        if (done_c) begin
            last_xfer_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (p_en && (load_cnt_q != CNT_W'(NUM_WORDS + 1))) begin
                    load_cnt_d = load_cnt_q + CNT_W'(1);
                end
                if (p_fall) begin
                    load_cnt_d = '0;
                    if (load_cnt_q == CNT_W'(NUM_WORDS)) begin
                        state_d     = READ;
                        rd_addr_d   = '0;
                        push_idx_d  = '0;
                        last_xfer_d = 1'b0;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            READ: begin
                ovr_err_d = p_rise;
                if (rd_en_c && (rd_addr_q == ADDR_W'(NUM_WORDS - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A burst starting on the exit cycle is the next frame, not an overrun.
                if (fifo_empty && !inflight_q && last_xfer_q) begin
                    state_d    = IDLE;
                    load_cnt_d = p_en ? CNT_W'(1) : '0;
                end else begin
                    ovr_err_d = p_rise;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            p_en_q      <= 1'b0;
            load_cnt_q  <= '0;
            rd_addr_q   <= '0;
            push_idx_q  <= '0;
            inflight_q  <= 1'b0;
            last_xfer_q <= 1'b0;
            len_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_en_q      <= p_en;
            load_cnt_q  <= load_cnt_d;
            rd_addr_q   <= rd_addr_d;
            push_idx_q  <= push_idx_d;
            inflight_q  <= rd_en_c;
            last_xfer_q <= last_xfer_d;
            len_err_q   <= len_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    assign rd_en     = rd_en_c;
    assign rd_addr   = rd_addr_q;
    assign out_data  = head.data;
    assign out_valid = !fifo_empty;
    assign out_last  = !fifo_empty && head.last;
    assign busy      = (state_q != IDLE);
    assign done      = done_c;
    assign len_err   = len_err_q;
    assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_parity_unload.sv
// Directed and randomized bench for parity_unload with a bank model and an expected-word queue.
module tb_parity_unload;

    localparam int NW = 6;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        p_en;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] par_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        len_err;
    logic        ovr_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] bank [8];
    logic [15:0] exp_q [$];
    int widx, outst, rd_cnt;
    int xfer_total = 0, done_total = 0, len_total = 0, ovr_total = 0, rd_total = 0;
    bit prev_stall;
    logic [15:0] stall_data;

    always #5 clk_in = ~clk_in;

    parity_unload dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .p_en      (p_en),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .par_data  (par_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err),
        .ovr_err   (ovr_err)
    );

    // Bank read port: data is valid exactly one cycle after the strobe.
    always @(posedge clk_in) begin
        if (rd_en) par_data <= bank[rd_addr];
        else       par_data <= 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: order, last/done marking, stall stability and read credit.
    always @(negedge clk_in) begin
        bit xfer;
        if (!rst) begin
            exp_q.delete();
            widx = 0; outst = 0; rd_cnt = 0; prev_stall = 0;
        end else begin
            xfer = out_valid && out_ready;
            if (!busy) rd_cnt = 0;
            if (rd_en) begin
                chk("rd_addr", 32'(rd_addr), 32'(rd_cnt));
                rd_cnt++;
                rd_total++;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid) chk("out_last", 32'(out_last), 32'(widx == NW - 1));
            chk("done", 32'(done), 32'(xfer && widx == NW - 1));
            if (xfer) begin
                chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                widx = (widx + 1) % NW;
                xfer_total++;
            end
            outst = outst + int'(rd_en) - int'(xfer);
            if (rd_en) chk("credit", 32'(outst <= 2), 32'd1);
            prev_stall = out_valid && !out_ready;
            stall_data = out_data;
            if (done)    done_total++;
            if (len_err) len_total++;
            if (ovr_err) ovr_total++;
        end
    end

    task automatic send(input int n, input bit frame);
        if (frame) for (int i = 0; i < NW; i++) exp_q.push_back(bank[i]);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1; p_en = 1'b1;
        end
        @(posedge clk_in); #1; p_en = 1'b0;
    endtask

    task automatic wait_quiet(input int mode);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk_in); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!busy && !out_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("quiet_timeout", 32'(ok), 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
        chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_len_err"},   32'(len_err),   32'd0);
        chk({tag, "_ovr_err"},   32'(ovr_err),   32'd0);
    endtask

    initial begin
        int x0, d0, l0, o0, r0, n;
        int first_rd, first_v, done_k;

        rst = 1'b0; p_en = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) bank[i] = 16'(16'hA0 + i);
        repeat (3) @(posedge clk_in);
        #1 chk_zero("reset");
        rst = 1'b1;
        out_ready = 1'b1;

        // Nominal frame: latency and throughput
        x0 = xfer_total; d0 = done_total; l0 = len_total; o0 = ovr_total;
        first_rd = -1; first_v = -1; done_k = -1;
        send(NW, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_in);
            if (rd_en && first_rd < 0) first_rd = k;
            if (out_valid && first_v < 0) first_v = k;
            if (done) begin done_k = k; break; end
        end
        chk("nom_first_rd", 32'(first_rd), 32'd1);
        chk("nom_first_valid", 32'(first_v), 32'd3);
        chk("nom_done_cycle", 32'(done_k), 32'd8);
        wait_quiet(0);
        chk("nom_words", 32'(xfer_total - x0), 32'd6);
        chk("nom_done_cnt", 32'(done_total - d0), 32'd1);
        chk("nom_len_err", 32'(len_total - l0), 32'd0);
        chk("nom_ovr_err", 32'(ovr_total - o0), 32'd0);

        // Backpressure 1,0,0,1
        x0 = xfer_total; d0 = done_total;
        send(NW, 1'b1);
        wait_quiet(1);
        chk("bp_words", 32'(xfer_total - x0), 32'd6);
        chk("bp_done_cnt", 32'(done_total - d0), 32'd1);

        // Bad lengths 4 and 7
        for (int t = 0; t < 2; t++) begin
            l0 = len_total; r0 = rd_total;
            send(t == 0 ? 4 : 7, 1'b0);
            repeat (4) @(posedge clk_in);
            #1;
            chk("badlen_len_err", 32'(len_total - l0), 32'd1);
            chk("badlen_no_read", 32'(rd_total - r0), 32'd0);
            chk("badlen_idle", 32'(busy), 32'd0);
        end

        // Overrun during READ
        x0 = xfer_total; l0 = len_total; o0 = ovr_total;
        send(NW, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (rd_en) break;
        end
        @(posedge clk_in); #1 p_en = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1 p_en = 1'b0;
        wait_quiet(0);
        repeat (3) @(posedge clk_in);
        #1;
        chk("ovr_pulse", 32'(ovr_total - o0), 32'd1);
        chk("ovr_words", 32'(xfer_total - x0), 32'd6);
        chk("ovr_len_err", 32'(len_total - l0), 32'd0);

        // Back-to-back: next burst begins on the DRAIN->IDLE cycle
        x0 = xfer_total; l0 = len_total; d0 = done_total;
        send(NW, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_in);
            if (done) break;
        end
        send(NW, 1'b1);
        wait_quiet(0);
        repeat (3) @(posedge clk_in);
        #1;
        chk("b2b_words", 32'(xfer_total - x0), 32'd12);
        chk("b2b_done_cnt", 32'(done_total - d0), 32'd2);
        chk("b2b_len_err", 32'(len_total - l0), 32'd0);

        // Randomized frames: random bank, random burst length, random ready
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) bank[i] = 16'($urandom);
            n = $urandom_range(4, 8);
            x0 = xfer_total; l0 = len_total;
            send(n, 1'(n == NW));
            wait_quiet(2);
            repeat (3) @(posedge clk_in);
            #1;
            chk("rnd_len_err", 32'(len_total - l0), 32'(n != NW));
            chk("rnd_words", 32'(xfer_total - x0), (n == NW) ? 32'd6 : 32'd0);
        end

        // Reset mid-frame, then a fresh frame
        for (int i = 0; i < 8; i++) bank[i] = 16'(16'hA0 + i);
        x0 = xfer_total;
        send(NW, 1'b1);
        for (int k = 0; k < 50 && (xfer_total - x0) < 3; k++) @(negedge clk_in);
        chk("mid_three_words", 32'(xfer_total - x0), 32'd3);
        @(posedge clk_in); #1 rst = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(posedge clk_in);
        #1 rst = 1'b1;
        x0 = xfer_total; d0 = done_total;
        send(NW, 1'b1);
        wait_quiet(0);
        chk("post_rst_words", 32'(xfer_total - x0), 32'd6);
        chk("post_rst_done", 32'(done_total - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
